ofm_drain_ctrl: RTL and testbench

Output-side drain sequencer for the compute cluster. After a total chunk completes, it reads each compute unit's output buffer in turn. It does this by driving the cluster's output-buffer select and sampling the returned output-buffer word. Each word is split into write-bus beats and pushed through a valid/ready write port toward output-feature-map SRAM. It is the consumer of the cluster's output buffer port, the mirror of the chunk-write path that fills the IFM/filter chunks.

---
 rtl/ofm_drain_ctrl.sv | 164 ++++++++++++++++
 tb/tb_ofm_drain_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ofm_drain_ctrl.sv
// Output-feature-map drain sequencer: selects each compute unit's output buffer in turn,
// captures the word and streams it as WR_W beats over a valid/ready write port.
module ofm_drain_ctrl #(
  parameter int unsigned COMPUTE_UNIT_NUM = 8,
  parameter int unsigned OUT_BUF_W        = 512,
  parameter int unsigned WR_W             = 128,
  parameter int unsigned ADDR_W           = 16,
  parameter int unsigned SEL_LAT          = 1,
  localparam int unsigned CU_W = (COMPUTE_UNIT_NUM > 1) ? $clog2(COMPUTE_UNIT_NUM) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 drain_start_i,
  input  logic [ADDR_W-1:0]    drain_base_addr_i,
  output logic [CU_W-1:0]      cu_sel_o,
  input  logic [OUT_BUF_W-1:0] out_buf_dat_i,
  output logic                 ofm_wr_valid_o,
  input  logic                 ofm_wr_ready_i,
  output logic [ADDR_W-1:0]    ofm_wr_addr_o,
  output logic [WR_W-1:0]      ofm_wr_data_o,
  output logic                 ofm_wr_last_o,
  output logic                 busy_o,
  output logic                 drain_done_o
);

  localparam int unsigned BEATS  = OUT_BUF_W / WR_W;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned CNT_W  = (SEL_LAT > 1) ? $clog2(SEL_LAT) : 1;

  localparam logic [CU_W-1:0]   CU_LAST   = CU_W'(COMPUTE_UNIT_NUM - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(SEL_LAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEL  = 2'd1,
    ST_SEND = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [CU_W-1:0]       cu_idx_q, cu_idx_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [OUT_BUF_W-1:0]  shift_q, shift_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  hs_c;
  logic [BEAT_W-1:0]     beat_inc_c;

  assign hs_c       = valid_q & ofm_wr_ready_i;
  assign beat_inc_c = BEAT_W'(beat_q + 1'b1);

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= ST_IDLE;
      cu_idx_q <= '0;
      beat_q   <= '0;
      cnt_q    <= '0;
      shift_q  <= '0;
      addr_q   <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cu_idx_q <= cu_idx_d;
      beat_q   <= beat_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      addr_q   <= addr_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state and registered-output logic; beats are contiguous so the
  // address simply advances by one per accepted beat from the latched base.
  always_comb begin
    state_d  = state_q;
    cu_idx_d = cu_idx_q;
    beat_d   = beat_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    addr_d   = addr_q;
    valid_d  = valid_q;
    last_d   = last_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (drain_start_i) begin
          state_d  = ST_SEL;
          cu_idx_d = '0;
          beat_d   = '0;
          cnt_d    = CNT_LOAD;
          addr_d   = drain_base_addr_i;
          valid_d  = 1'b0;
          last_d   = 1'b0;
          busy_d   = 1'b1;
        end
      end

      ST_SEL: begin
        if (cnt_q == '0) begin
          state_d = ST_SEND;
          shift_d = out_buf_dat_i;
          beat_d  = '0;
          valid_d = 1'b1;
          last_d  = (cu_idx_q == CU_LAST) && (BEAT_LAST == '0);
        end else begin
          cnt_d = CNT_W'(cnt_q - 1'b1);
        end
      end

      ST_SEND: begin
        if (hs_c) begin
          shift_d = shift_q >> WR_W;
          addr_d  = ADDR_W'(addr_q + 1'b1);
          if (beat_q == BEAT_LAST) begin
            beat_d  = '0;
            valid_d = 1'b0;
            last_d  = 1'b0;
            if (cu_idx_q != CU_LAST) begin
              state_d  = ST_SEL;
              cu_idx_d = CU_W'(cu_idx_q + 1'b1);
              cnt_d    = CNT_LOAD;
            end else begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end else begin
            beat_d = beat_inc_c;
            last_d = (cu_idx_q == CU_LAST) && (beat_inc_c == BEAT_LAST);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign cu_sel_o       = cu_idx_q;
  assign ofm_wr_valid_o = valid_q;
  assign ofm_wr_addr_o  = addr_q;
  assign ofm_wr_data_o  = shift_q[WR_W-1:0];
  assign ofm_wr_last_o  = last_q;
  assign busy_o         = busy_q;
  assign drain_done_o   = done_q;

endmodule

// File: tb/tb_ofm_drain_ctrl.sv
// Randomized bench for ofm_drain_ctrl: a queue-based model of the expected beat
// stream is checked against two instances (select latency 1 and 3).
module tb_ofm_drain_ctrl;

  localparam int unsigned N_CU  = 8;
  localparam int unsigned OBW   = 512;
  localparam int unsigned WW    = 128;
  localparam int unsigned AW    = 16;
  localparam int unsigned BEATS = OBW / WW;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [WW-1:0] data;
    logic          last;
  } beat_t;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic           start1, start3;
  logic [AW-1:0]  base_i;
  logic [OBW-1:0] out_buf;
  logic           ready;

  logic [2:0]    sel1, sel3v;
  logic          v1, v3, l1, l3, b1, b3, dn1, dn3;
  logic [AW-1:0] a1, a3;
  logic [WW-1:0] d1, d3;

  logic [2:0]    m_sel;
  logic          m_valid, m_last, m_busy, m_done;
  logic [AW-1:0] m_addr;
  logic [WW-1:0] m_data;

  bit  sel3 = 1'b0;
  bit  rnd_ready = 1'b0;
  bit  mon_en = 1'b0;
  bit  stall_pend = 1'b0;
  bit  exp_done_next = 1'b0;
  int  lat = 1;
  int  age = 0;
  logic [2:0] prev_sel = '0;
  logic       prev_busy = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int beats_seen = 0;
  int busy_cycles = 0;
  int done_seen = 0;

  logic [OBW-1:0] words [N_CU];
  beat_t exp_q[$];
  beat_t held;
  beat_t e;

  always #5 clk_i = ~clk_i;

  ofm_drain_ctrl #(.COMPUTE_UNIT_NUM(N_CU), .OUT_BUF_W(OBW), .WR_W(WW), .ADDR_W(AW), .SEL_LAT(1)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .drain_start_i(start1), .drain_base_addr_i(base_i),
    .cu_sel_o(sel1), .out_buf_dat_i(out_buf), .ofm_wr_valid_o(v1), .ofm_wr_ready_i(ready),
    .ofm_wr_addr_o(a1), .ofm_wr_data_o(d1), .ofm_wr_last_o(l1), .busy_o(b1), .drain_done_o(dn1)
  );

  ofm_drain_ctrl #(.COMPUTE_UNIT_NUM(N_CU), .OUT_BUF_W(OBW), .WR_W(WW), .ADDR_W(AW), .SEL_LAT(3)) u_dut3 (
    .clk_i(clk_i), .rst_i(rst_i), .drain_start_i(start3), .drain_base_addr_i(base_i),
    .cu_sel_o(sel3v), .out_buf_dat_i(out_buf), .ofm_wr_valid_o(v3), .ofm_wr_ready_i(ready),
    .ofm_wr_addr_o(a3), .ofm_wr_data_o(d3), .ofm_wr_last_o(l3), .busy_o(b3), .drain_done_o(dn3)
  );

  assign m_sel   = sel3 ? sel3v : sel1;
  assign m_valid = sel3 ? v3 : v1;
  assign m_addr  = sel3 ? a3 : a1;
  assign m_data  = sel3 ? d3 : d1;
  assign m_last  = sel3 ? l3 : l1;
  assign m_busy  = sel3 ? b3 : b1;
  assign m_done  = sel3 ? dn3 : dn1;

  task automatic chk(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  function automatic logic [OBW-1:0] rand_word();
    logic [OBW-1:0] w;
    for (int i = 0; i < int'(OBW / 32); i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic fill_random();
    for (int k = 0; k < int'(N_CU); k++) words[k] = rand_word();
  endtask

  // Expected stream: CU-major, beat-minor, address = base + cu*BEATS + beat mod 2^AW
  task automatic push_drain(input logic [AW-1:0] base);
    beat_t b;
    for (int k = 0; k < int'(N_CU); k++) begin
      for (int j = 0; j < int'(BEATS); j++) begin
        b.addr = AW'(int'(base) + k * int'(BEATS) + j);
        b.data = words[k][j*WW +: WW];
        b.last = (k == int'(N_CU) - 1) && (j == int'(BEATS) - 1);
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic clear_counts();
    beats_seen = 0;
    busy_cycles = 0;
    done_seen = 0;
  endtask

  task automatic start_drain(input logic [AW-1:0] base);
    @(posedge clk_i); #1;
    base_i = base;
    if (sel3) start3 = 1'b1; else start1 = 1'b1;
    @(posedge clk_i); #1;
    start1 = 1'b0;
    start3 = 1'b0;
  endtask

  task automatic wait_beats(input int target, input string tag);
    int c = 0;
    while (beats_seen < target && c < 3000) begin
      @(posedge clk_i);
      c++;
    end
    chk(tag, WW'(beats_seen >= target), WW'(1));
  endtask

  task automatic wait_done(input int target, input string tag);
    int c = 0;
    while (done_seen < target && c < 3000) begin
      @(posedge clk_i);
      c++;
    end
    chk(tag, WW'(done_seen), WW'(target));
    repeat (2) @(posedge clk_i);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_valid"}, WW'(v1), WW'(0));
    chk({tag, "_busy"},  WW'(b1), WW'(0));
    chk({tag, "_done"},  WW'(dn1), WW'(0));
    chk({tag, "_sel"},   WW'(sel1), WW'(0));
    chk({tag, "_addr"},  WW'(a1), WW'(0));
    chk({tag, "_data"},  d1, WW'(0));
    chk({tag, "_last"},  WW'(l1), WW'(0));
  endtask

  // Output-buffer model plus beat monitor, both evaluated away from the active edge
  always @(negedge clk_i) begin
    if (m_sel != prev_sel || (m_busy && !prev_busy)) age = 1;
    else if (age < 1000) age++;
    prev_sel  = m_sel;
    prev_busy = m_busy;
    out_buf   = (age >= lat) ? words[m_sel] : rand_word();

    if (mon_en) begin
      if (stall_pend) begin
        chk("stall_valid", WW'(m_valid), WW'(1));
        chk("stall_addr", WW'(m_addr), WW'(held.addr));
        chk("stall_data", m_data, held.data);
        chk("stall_last", WW'(m_last), WW'(held.last));
      end
      if (exp_done_next) begin
        chk("done_pulse", WW'(m_done), WW'(1));
        chk("busy_after_done", WW'(m_busy), WW'(0));
        exp_done_next = 1'b0;
      end else begin
        chk("done_spurious", WW'(m_done), WW'(0));
      end
      if (m_busy) busy_cycles++;
      if (m_done) done_seen++;
      ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m_valid && ready) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("beat_addr", WW'(m_addr), WW'(e.addr));
          chk("beat_data", m_data, e.data);
          chk("beat_last", WW'(m_last), WW'(e.last));
          if (e.last) exp_done_next = 1'b1;
        end
        beats_seen++;
      end
      stall_pend = m_valid && !ready;
      held = '{addr: m_addr, data: m_data, last: m_last};
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_i  = 1'b0;
    start1 = 1'b0;
    start3 = 1'b0;
    base_i = '0;
    ready  = 1'b1;
    for (int k = 0; k < int'(N_CU); k++) words[k] = '0;
    repeat (3) @(posedge clk_i);
    #1;
    chk_idle_outputs("reset");
    rst_i  = 1'b1;
    mon_en = 1'b1;

    // Patterned words, ready held high
    for (int k = 0; k < int'(N_CU); k++) words[k] = {16{32'(k)}};
    clear_counts();
    push_drain(16'h0100);
    start_drain(16'h0100);
    wait_done(1, "t1_done");
    chk("t1_beats", WW'(beats_seen), WW'(32));
    chk("t1_cycles", WW'(busy_cycles), WW'(40));
    chk("t1_queue", WW'(exp_q.size()), WW'(0));

    // Random data with random backpressure
    for (int r = 0; r < 3; r++) begin
      fill_random();
      clear_counts();
      rnd_ready = 1'b1;
      push_drain(16'h0100);
      start_drain(16'h0100);
      wait_done(1, "t2_done");
      rnd_ready = 1'b0;
      chk("t2_beats", WW'(beats_seen), WW'(32));
      chk("t2_queue", WW'(exp_q.size()), WW'(0));
    end

    // Address wrap
    fill_random();
    clear_counts();
    push_drain(16'hFFF8);
    start_drain(16'hFFF8);
    wait_done(1, "t3_done");
    chk("t3_beats", WW'(beats_seen), WW'(32));

    // Start mid-drain is ignored; start in the done cycle begins a new drain
    fill_random();
    clear_counts();
    push_drain(16'h2000);
    start_drain(16'h2000);
    wait_beats(10, "t4_reach10");
    start_drain(16'h5555);
    wait_beats(31, "t4_reach31");
    push_drain(16'h3000);
    @(posedge clk_i); #1;
    base_i = 16'h3000;
    start1 = 1'b1;
    @(posedge clk_i); #1;
    start1 = 1'b0;
    wait_done(2, "t4_done");
    chk("t4_beats", WW'(beats_seen), WW'(64));
    chk("t4_queue", WW'(exp_q.size()), WW'(0));

    // Select latency 3 with garbage before the word settles
    sel3 = 1'b1;
    lat  = 3;
    fill_random();
    @(posedge clk_i); #1;
    clear_counts();
    push_drain(16'h0800);
    start_drain(16'h0800);
    wait_done(1, "t5_done");
    chk("t5_beats", WW'(beats_seen), WW'(32));
    chk("t5_cycles", WW'(busy_cycles), WW'(56));
    sel3 = 1'b0;
    lat  = 1;
    @(posedge clk_i); #1;

    // Reset during CU 3 beat 2
    fill_random();
    clear_counts();
    push_drain(16'h0400);
    start_drain(16'h0400);
    wait_beats(14, "t6_reach14");
    #1;
    rst_i  = 1'b0;
    mon_en = 1'b0;
    #1;
    chk_idle_outputs("midrst");
    exp_q.delete();
    stall_pend    = 1'b0;
    exp_done_next = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    clear_counts();
    mon_en = 1'b1;
    repeat (6) @(posedge clk_i);
    #1;
    chk("t6_no_done", WW'(done_seen), WW'(0));
    chk("t6_idle_busy", WW'(b1), WW'(0));
    fill_random();
    push_drain(16'h0A00);
    start_drain(16'h0A00);
    wait_done(1, "t6_done");
    chk("t6_beats", WW'(beats_seen), WW'(32));
    chk("t6_cycles", WW'(busy_cycles), WW'(40));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
